// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr} pairs with
// valid/ready on both sides and a synchronous flush for branch redirects.
module instr_queue #(
    parameter type         T     = logic [31:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  T                       in_instr,
    input  T                       in_pc,
    output logic                   in_ready,
    output logic                   out_valid,
    output T                       out_instr,
    output T                       out_pc,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    T              instr_mem [DEPTH];
    T              pc_mem    [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // in_ready looks only at occupancy and flush, never at out_ready.
    assign in_ready  = (count_q != CntW'(DEPTH)) && !flush;
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem[head_q] : '0;
    assign out_pc    = out_valid ? pc_mem[head_q]    : '0;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            // Storage is left stale; count=0 hides it from the output.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                instr_mem[tail_q] <= in_instr;
                pc_mem[tail_q]    <= in_pc;
                tail_q            <= tail_q + PtrW'(1);
            end
            if (pop) begin
                head_q <= head_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed-vector and scoreboard bench for instr_queue (DEPTH=4).
module tb_instr_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;

    instr_queue #(.T(logic [31:0]), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at negedge; outputs are compared 1 time unit later.
    task automatic drive(input logic f, input logic iv, input logic [31:0] pc, input logic ordy);
        @(negedge clk);
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ir, input logic ov,
                           input logic [31:0] pc, input int cnt);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_pc"},    out_pc,         pc);
        chk({tag, ".out_instr"}, out_instr,      ov ? instr_of(pc) : 32'h0);
        chk({tag, ".count"},     32'(count),     32'(cnt));
    endtask

    typedef struct {
        logic        f;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_pc;
        int          exp_cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic f, input logic iv, input logic [31:0] pc,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [31:0] epc, input int cnt);
        vec_t v;
        v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_pc = epc; v.exp_cnt = cnt;
        return v;
    endfunction

    logic [31:0] sb[$];

    initial begin
        //              f  iv pc          ordy ir ov exp_pc      cnt
        // one-cycle latency into an empty queue
        vecs[0]  = mk(0, 1, 32'h100, 0, 1, 0, 32'h0,   0);
        vecs[1]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h100, 1);
        vecs[2]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h100, 1);
        vecs[3]  = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,   0);
        // fill to full, fifth push held until a pop frees a slot
        vecs[4]  = mk(0, 1, 32'h0,   0, 1, 0, 32'h0,   0);
        vecs[5]  = mk(0, 1, 32'h4,   0, 1, 1, 32'h0,   1);
        vecs[6]  = mk(0, 1, 32'h8,   0, 1, 1, 32'h0,   2);
        vecs[7]  = mk(0, 1, 32'hC,   0, 1, 1, 32'h0,   3);
        vecs[8]  = mk(0, 1, 32'h10,  0, 0, 1, 32'h0,   4);
        vecs[9]  = mk(0, 1, 32'h10,  1, 0, 1, 32'h0,   4);
        vecs[10] = mk(0, 1, 32'h10,  0, 1, 1, 32'h4,   3);
        vecs[11] = mk(0, 0, 32'h0,   0, 0, 1, 32'h4,   4);
        vecs[12] = mk(0, 0, 32'h0,   1, 0, 1, 32'h4,   4);
        vecs[13] = mk(0, 0, 32'h0,   1, 1, 1, 32'h8,   3);
        vecs[14] = mk(0, 0, 32'h0,   1, 1, 1, 32'hC,   2);
        vecs[15] = mk(0, 0, 32'h0,   1, 1, 1, 32'h10,  1);
        vecs[16] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,   0);
        // pop on empty is ignored
        vecs[17] = mk(0, 0, 32'h0,   1, 1, 0, 32'h0,   0);
        vecs[18] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,   0);
        // flush with simultaneous push and pop
        vecs[19] = mk(0, 1, 32'h200, 0, 1, 0, 32'h0,   0);
        vecs[20] = mk(0, 1, 32'h204, 0, 1, 1, 32'h200, 1);
        vecs[21] = mk(1, 1, 32'h300, 1, 0, 1, 32'h200, 2);
        vecs[22] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,   0);
        vecs[23] = mk(0, 1, 32'h400, 0, 1, 0, 32'h0,   0);
        vecs[24] = mk(0, 0, 32'h0,   0, 1, 1, 32'h400, 1);
        vecs[25] = mk(0, 0, 32'h0,   1, 1, 1, 32'h400, 1);
        vecs[26] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,   0);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0;
        #1;
        chk_out("reset", 1, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].f, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_ov,
                    vecs[i].exp_pc, vecs[i].exp_cnt);
        end

        // Asynchronous reset with three entries held.
        drive(0, 1, 32'h500, 0);
        drive(0, 1, 32'h504, 0);
        drive(0, 1, 32'h508, 0);
        drive(0, 0, 32'h0,   0);
        chk("pre_reset.count", 32'(count), 32'd3);
        reset = 1'b1;
        #1;
        chk_out("midreset", 1, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0);
        reset = 1'b0;
        drive(0, 1, 32'h600, 0);
        drive(0, 1, 32'h604, 0);
        chk_out("post_reset0", 1, 1, 32'h600, 1);
        drive(0, 0, 32'h0, 1);
        chk_out("post_reset1", 1, 1, 32'h600, 2);
        drive(0, 0, 32'h0, 1);
        chk_out("post_reset2", 1, 1, 32'h604, 1);
        drive(0, 0, 32'h0, 0);
        chk_out("post_reset3", 1, 0, 32'h0, 0);

        // Continuous push+pop: pointers wrap twice, count stays at 1.
        drive(0, 1, 32'h0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 32'(4 * (i + 1)), 1);
            chk_out($sformatf("stream%0d", i), 1, 1, 32'(4 * i), 1);
        end
        drive(0, 0, 32'h0, 1);
        chk_out("stream_tail", 1, 1, 32'h28, 1);
        drive(0, 0, 32'h0, 0);
        chk_out("stream_empty", 1, 0, 32'h0, 0);

        // Random traffic against a queue scoreboard.
        begin
            logic [31:0] next_pc = 32'h1000;
            for (int c = 0; c < 1000; c++) begin
                logic iv, ordy, do_push, do_pop;
                iv   = 1'($urandom_range(0, 1));
                ordy = 1'($urandom_range(0, 1));
                drive(0, iv, next_pc, ordy);
                chk("rnd.count", 32'(count), 32'(sb.size()));
                chk("rnd.count_range", 32'(count <= 3'(DEPTH)), 32'd1);
                chk("rnd.in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
                chk("rnd.out_valid", 32'(out_valid), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    chk("rnd.out_pc", out_pc, sb[0]);
                    chk("rnd.out_instr", out_instr, instr_of(sb[0]));
                end
                do_push = iv && (sb.size() != DEPTH);
                do_pop  = ordy && (sb.size() != 0);
                if (do_pop) void'(sb.pop_front());
                if (do_push) begin
                    sb.push_back(next_pc);
                    next_pc = next_pc + 32'd4;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
